// File: rtl/lcd_nibble_reader.sv
// 4-bit LCD read sequencer: issues one RS/RW setup phase and two E pulses,
// then assembles the byte from the pad, high nibble first. Optionally keeps
// re-reading the busy flag until it clears or the poll limit is reached.
module lcd_nibble_reader #(
  parameter int T_AS     = 2,
  parameter int T_PW     = 12,
  parameter int T_LOW    = 26,
  parameter int MAX_POLL = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       sf_e,
  output logic       e,
  output logic       rs,
  output logic       rw,
  input  logic [3:0] db_in,
  output logic       db_oe
);

  localparam int PH_MAX = (T_AS > T_PW) ? ((T_AS > T_LOW) ? T_AS : T_LOW)
                                        : ((T_PW > T_LOW) ? T_PW : T_LOW);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int PC_W   = $clog2(MAX_POLL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HI1, S_LO1, S_HI2, S_LO2, S_DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ph_cnt;
  logic [PC_W-1:0]   poll_cnt;
  logic              poll_mode;
  logic              poll_again;

  // Phase counter load value: the counter runs from cycles-1 down to 0.
  function automatic logic [PH_W-1:0] ph_load(input int cycles);
    return PH_W'(cycles - 1);
  endfunction

  // Another busy-flag read is due when polling, BF is still set and the
  // read just finished is not the last one allowed.
  function automatic logic poll_more(input logic mode, input logic bf,
                                     input logic [PC_W-1:0] cnt);
    return mode && bf && ((int'(cnt) + 1) < MAX_POLL);
  endfunction

  // Sequencer: state, phase timing, pin drive and response, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      poll_cnt    <= '0;
      poll_mode   <= 1'b0;
      poll_again  <= 1'b0;
      ready       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= 8'h00;
      e           <= 1'b0;
      rs          <= 1'b0;
      rw          <= 1'b0;
      sf_e        <= 1'b1;
      db_oe       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      sf_e      <= 1'b1;
      db_oe     <= 1'b0;
      case (state)
        S_IDLE: begin
          ready <= 1'b1;
          e     <= 1'b0;
          rs    <= 1'b0;
          rw    <= 1'b0;
          if (req && ready) begin
            ready       <= 1'b0;
            poll_mode   <= req_poll & ~req_rs;
            poll_cnt    <= '0;
            rsp_timeout <= 1'b0;
            rs          <= req_rs;
            rw          <= 1'b1;
            ph_cnt      <= ph_load(T_AS);
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (ph_cnt == '0) begin
            e      <= 1'b1;
            ph_cnt <= ph_load(T_PW);
            state  <= S_HI1;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_HI1: begin
          if (ph_cnt == '0) begin
            rsp_data[7:4] <= db_in;
            e             <= 1'b0;
            ph_cnt        <= ph_load(T_LOW);
            state         <= S_LO1;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_LO1: begin
          if (ph_cnt == '0) begin
            e      <= 1'b1;
            ph_cnt <= ph_load(T_PW);
            state  <= S_HI2;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_HI2: begin
          if (ph_cnt == '0) begin
            rsp_data[3:0] <= db_in;
            e             <= 1'b0;
            ph_cnt        <= ph_load(T_LOW);
            state         <= S_LO2;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_LO2: begin
          if (ph_cnt == '0) begin
            state <= S_DONE;
            if (poll_more(poll_mode, rsp_data[7], poll_cnt)) begin
              poll_again <= 1'b1;
              poll_cnt   <= poll_cnt + PC_W'(1);
            end else begin
              poll_again  <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_timeout <= poll_mode & rsp_data[7];
            end
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        S_DONE: begin
          e <= 1'b0;
          if (poll_again) begin
            poll_again <= 1'b0;
            ph_cnt     <= ph_load(T_AS);
            state      <= S_SETUP;
          end else begin
            ready <= 1'b1;
            rs    <= 1'b0;
            rw    <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          e     <= 1'b0;
          rs    <= 1'b0;
          rw    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_nibble_reader.md
LCD_NIBBLE_READER -- requirements
Module: lcd_nibble_reader

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- T_AS, 2: cycles RS/RW are stable before E rises.
- T_PW, 12: cycles E is high per nibble.
- T_LOW, 26: cycles E is low after each nibble.
- MAX_POLL, 1000: maximum busy-flag reads per poll request.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst_n, in, 1: reset.
- req, in, 1: start a read transaction.
- req_rs, in, 1: 0 = read busy flag/address counter; 1 = read DDRAM/CGRAM data.
- req_poll, in, 1: with req_rs=0, repeat reads until BF=0.
- ready, out, 1: block idle; requests accepted.
- rsp_valid, out, 1: one-cycle result strobe.
- rsp_data, out, 8: byte read, high nibble first on bus.
- rsp_timeout, out, 1: qualifies rsp_valid; poll limit hit.
- sf_e, out, 1: StrataFlash disable.
- e, out, 1: LCD enable.
- rs, out, 1: LCD register select.
- rw, out, 1: LCD read/write; 1 = read.
- db_in, in, 4: LCD data nibble from the external pad.
- db_oe, out, 1: pad drive enable; always 0 from this block.

REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 SHALL register every LCD-side output (e, rs, rw, sf_e, db_oe); no combinational path from req to the pins.
REQ-005 SHALL implement the FSM IDLE -> SETUP -> HI1 -> LO1 -> HI2 -> LO2 -> DONE -> IDLE.
- SETUP: T_AS cycles.
- HI1, HI2: T_PW cycles each.
- LO1, LO2: T_LOW cycles each.
- DONE: 1 cycle.
REQ-006 SHALL assert ready only in IDLE; a request is accepted on a clk edge with req=1 and ready=1, latching req_rs and req_poll.
REQ-007 SHALL ignore req in all states other than IDLE, including DONE.
REQ-008 SHALL set rw=1 and rs to the latched req_rs from SETUP through LO2, with e=0 in SETUP, LO1 and LO2.
REQ-009 SHALL drive e=1 throughout HI1 and HI2.
REQ-010 SHALL sample db_in on the last cycle of HI1 into rsp_data[7:4] and on the last cycle of HI2 into rsp_data[3:0].
REQ-011 SHALL, in IDLE, drive e=0, rs=0, rw=0, sf_e=1, db_oe=0.
REQ-012 Non-poll transaction: SHALL pulse rsp_valid for exactly the DONE cycle, with rsp_timeout=0.
- Accept edge k -> rsp_valid high in the cycle after edge k+T_AS+2*T_PW+2*T_LOW (k+78 at defaults).
REQ-013 Poll transaction: in DONE, if the sampled bit7=1 and the poll count is below MAX_POLL, SHALL return to SETUP without asserting rsp_valid, and increment the poll count.
REQ-014 Poll end:
- bit7=0 -> rsp_valid=1, rsp_timeout=0.
- Poll count reaches MAX_POLL with bit7=1 -> rsp_valid=1, rsp_timeout=1.
- rsp_data = last byte read in both cases.
REQ-015 Poll count SHALL be cleared on accept; MAX_POLL=1 SHALL behave as a single read with a timeout check.
REQ-016 req_poll with req_rs=1 SHALL be treated as a non-poll read.
REQ-017 rsp_data SHALL hold its value between transactions; it changes only at the REQ-010 sample points.
REQ-018 Counters SHALL be sized for max(T_AS, T_PW, T_LOW) and MAX_POLL without wrap; each phase counter reloads on state entry.
REQ-019 db_oe SHALL never be asserted; rw SHALL never be 0 while e=1.

Reset
REQ-020 On rst_n=0, SHALL immediately force the following, regardless of state (including mid-transaction with e=1):
- IDLE state.
- e=0, rs=0, rw=0, sf_e=1, db_oe=0.
- ready=0, rsp_valid=0, rsp_timeout=0, rsp_data=8'h00.
- All counters = 0.
REQ-021 SHALL assert ready on the first clk edge after rst_n deasserts; an aborted transaction SHALL produce no rsp_valid.

Verification
REQ-022 Single data read: req=1, req_rs=1, db_in=4'hA in HI1 and 4'h5 in HI2 -> rsp_valid one cycle, 78 cycles after accept, rsp_data=8'hA5, rs=1, rw=1 throughout.
REQ-023 Busy poll: req_rs=0, req_poll=1, model returns 8'h8C three times then 8'h0C -> exactly one rsp_valid, rsp_data=8'h0C, rsp_timeout=0, 4 E-pair sequences observed.
REQ-024 Poll timeout: MAX_POLL=3, model always returns 8'hFF -> rsp_valid with rsp_timeout=1, rsp_data=8'hFF, exactly 3 reads.
REQ-025 Busy req: req held high throughout a transaction -> second accept only after DONE, on the edge ready=1; no overlap; e pulse width always T_PW.
REQ-026 Reset mid-read: rst_n=0 while e=1 in HI2 -> e=0, rw=0 in the same cycle (asynchronous); no rsp_valid; ready=1 one edge after release.
REQ-027 Assertions over all tests: db_oe==0; not (e and !rw); sf_e==1.
